// File: rtl/spy_pkg.sv
// Shared definitions for the morse-entry game: FSM state encodings,
// morse symbol constants and code geometry.
package spy_pkg;

   localparam int SYM_W   = 2;
   localparam int NUM_SYM = 5;
   localparam int CODE_W  = SYM_W * NUM_SYM;

   localparam logic [SYM_W-1:0] MORSE_NONE = 2'b00;
   localparam logic [SYM_W-1:0] MORSE_DOT  = 2'b01;
   localparam logic [SYM_W-1:0] MORSE_LINE = 2'b11;

   // A code with no symbols entered at all
   localparam logic [CODE_W-1:0] CODE_EMPTY = {NUM_SYM{MORSE_NONE}};

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLEAR     = 3'd1,
      ST_P1_ENTRY  = 3'd2,
      ST_P2_ENTRY  = 3'd3,
      ST_COMPARE   = 3'd4,
      ST_RESULT    = 3'd5,
      ST_GAME_OVER = 3'd6
   } roundState_e;

endpackage

// File: rtl/round_sequencer_entry_timer.sv
// Entry-phase watchdog: counts cycles while run_i is high and flags
// expiry once TIMEOUT_CYCLES cycles have elapsed since the last clear.
// Only instantiated when ENTRY_TIMEOUT_EN is defined.
module entry_timer #(
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int CNT_W          = 26
) (
   input  logic clock,
   input  logic resetn,
   input  logic clear_i,
   input  logic run_i,
   output logic expired_o
);

   logic [CNT_W-1:0] count_q;

   assign expired_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count up while running; hold at the terminal value so expiry stays asserted until cleared
   always_ff @(posedge clock) begin
      if (!resetn || clear_i) begin
         count_q <= '0;
      end else if (run_i && !expired_o) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller for the two morse-entry players: clears both players,
// opens player 1 then player 2 entry, compares codes, scores and counts rounds.
// Optional feature macro: ENTRY_TIMEOUT_EN adds a per-entry-phase timeout.
module round_sequencer
   import spy_pkg::*;
#(
   parameter int ROUNDS         = 8,
   parameter int TIMEOUT_CYCLES = 50000000,
   parameter int CNT_W          = 26
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              p1_done_i,
   input  logic              p2_done_i,
   input  logic [CODE_W-1:0] p1_code_i,
   input  logic [CODE_W-1:0] p2_code_i,
   output logic              p1_clear_o,
   output logic              p2_clear_o,
   output logic              p1_en_o,
   output logic              p2_en_o,
   output logic              round_match_o,
   output logic [3:0]        score_o,
   output logic [3:0]        round_num_o,
   output logic              timeout_o,
   output logic              game_over_o,
   output logic [2:0]        state_o
);

   roundState_e state_q, state_d;
   logic        clear_q, p1En_q, p2En_q, gameOver_q;
   logic        roundMatch_q, timeout_q;
   logic [3:0]  score_q, roundNum_q;
   logic        timerExpired;
   logic        inEntry;
   logic        matchNow;

   assign inEntry = (state_q == ST_P1_ENTRY) || (state_q == ST_P2_ENTRY);

`ifdef ENTRY_TIMEOUT_EN
   logic timerClear;

   // Timer restarts in every non-entry state and on every entry-state exit
   assign timerClear = !inEntry || (state_d != state_q);

   entry_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_entry_timer (
      .clock     (clock),
      .resetn    (resetn),
      .clear_i   (timerClear),
      .run_i     (inEntry),
      .expired_o (timerExpired)
   );
`else
   logic unusedTimerCfg;

   assign unusedTimerCfg = (TIMEOUT_CYCLES != 0) ^ (CNT_W != 0);
   assign timerExpired   = 1'b0;
`endif

   // An empty code never matches, nor does a round that ended by timeout
   assign matchNow = (p1_code_i == p2_code_i) && (p1_code_i != CODE_EMPTY) && !timeout_q;

   // Next-state selection; a done input always beats a same-cycle timer expiry
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (start_i) state_d = ST_CLEAR;
         ST_CLEAR:     state_d = ST_P1_ENTRY;
         ST_P1_ENTRY: begin
            if (p1_done_i)         state_d = ST_P2_ENTRY;
            else if (timerExpired) state_d = ST_COMPARE;
         end
         ST_P2_ENTRY: begin
            if (p2_done_i || timerExpired) state_d = ST_COMPARE;
         end
         ST_COMPARE:   state_d = ST_RESULT;
         ST_RESULT:    state_d = (roundNum_q == 4'(ROUNDS)) ? ST_GAME_OVER : ST_CLEAR;
         ST_GAME_OVER: if (start_i) state_d = ST_CLEAR;
         default:      state_d = ST_IDLE;
      endcase
   end

   // State, registered Moore outputs (decoded from the next state) and round bookkeeping
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         clear_q      <= 1'b0;
         p1En_q       <= 1'b0;
         p2En_q       <= 1'b0;
         gameOver_q   <= 1'b0;
         roundMatch_q <= 1'b0;
         timeout_q    <= 1'b0;
         score_q      <= '0;
         roundNum_q   <= '0;
      end else begin
         state_q    <= state_d;
         clear_q    <= (state_d == ST_CLEAR);
         p1En_q     <= (state_d == ST_P1_ENTRY);
         p2En_q     <= (state_d == ST_P2_ENTRY);
         gameOver_q <= (state_d == ST_GAME_OVER);

         case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
               if (start_i) begin
                  score_q      <= '0;
                  roundNum_q   <= '0;
                  roundMatch_q <= 1'b0;
                  timeout_q    <= 1'b0;
               end
            end
            ST_P1_ENTRY: begin
               if (!p1_done_i && timerExpired) timeout_q <= 1'b1;
            end
            ST_P2_ENTRY: begin
               if (!p2_done_i && timerExpired) timeout_q <= 1'b1;
            end
            ST_COMPARE: begin
               roundMatch_q <= matchNow;
               score_q      <= score_q + {3'b000, matchNow};
               roundNum_q   <= roundNum_q + 1'b1;
            end
            ST_RESULT: begin
               if (state_d == ST_CLEAR) timeout_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign p1_clear_o    = clear_q;
   assign p2_clear_o    = clear_q;
   assign p1_en_o       = p1En_q;
   assign p2_en_o       = p2En_q;
   assign round_match_o = roundMatch_q;
   assign score_o       = score_q;
   assign round_num_o   = roundNum_q;
   assign timeout_o     = timeout_q;
   assign game_over_o   = gameOver_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed testbench for round_sequencer with ROUNDS=2, TIMEOUT_CYCLES=10.
// Timeout scenarios are exercised when ENTRY_TIMEOUT_EN is defined.
module tb_round_sequencer;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       p1Done = 1'b0;
   logic       p2Done = 1'b0;
   logic [9:0] p1Code = '0;
   logic [9:0] p2Code = '0;
   logic       p1Clear, p2Clear, p1En, p2En, roundMatch, timeout, gameOver;
   logic [3:0] score, roundNum;
   logic [2:0] state;

   int checkCount = 0;
   int passCount  = 0;

   round_sequencer #(
      .ROUNDS         (2),
      .TIMEOUT_CYCLES (10),
      .CNT_W          (4)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .start_i       (start),
      .p1_done_i     (p1Done),
      .p2_done_i     (p2Done),
      .p1_code_i     (p1Code),
      .p2_code_i     (p2Code),
      .p1_clear_o    (p1Clear),
      .p2_clear_o    (p2Clear),
      .p1_en_o       (p1En),
      .p2_en_o       (p2En),
      .round_match_o (roundMatch),
      .score_o       (score),
      .round_num_o   (roundNum),
      .timeout_o     (timeout),
      .game_over_o   (gameOver),
      .state_o       (state)
   );

   // 10-time-unit clock
   always #5 clock = ~clock;

   // Advance one clock edge and settle 1 unit past it before sampling or driving
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Play one full round from CLEAR: leaves the DUT in RESULT
   task automatic applyStimulus(input logic [9:0] c1, input logic [9:0] c2);
      p1Code = c1;
      p2Code = c2;
      tick();
      p1Done = 1'b1;
      tick();
      p1Done = 1'b0;
      p2Done = 1'b1;
      tick();
      p2Done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(3);
      resetn = 1'b1;
      tick();
      checkCount++;
      if (state !== 3'd0) $display("[TB] FAIL reset_state got=%0d exp=0", state);
      else passCount++;
      checkCount++;
      if ({p1Clear, p2Clear, p1En, p2En, roundMatch, timeout, gameOver} !== 7'b0)
         $display("[TB] FAIL reset_flags got=%b exp=0000000",
                  {p1Clear, p2Clear, p1En, p2En, roundMatch, timeout, gameOver});
      else passCount++;
      checkCount++;
      if ({score, roundNum} !== 8'h00) $display("[TB] FAIL reset_counts got=%h exp=00", {score, roundNum});
      else passCount++;
      p1Done = 1'b1;
      p2Done = 1'b1;
      tick(2);
      p1Done = 1'b0;
      p2Done = 1'b0;
      checkCount++;
      if (state !== 3'd0) $display("[TB] FAIL idle_ignores_done got=%0d exp=0", state);
      else passCount++;
   endtask

   task automatic test_match();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkCount++;
      if (state !== 3'd1 || p1Clear !== 1'b1 || p2Clear !== 1'b1)
         $display("[TB] FAIL clear_enter got st=%0d clr=%b%b exp st=1 clr=11", state, p1Clear, p2Clear);
      else passCount++;
      p1Code = 10'h1D7;
      p2Code = 10'h1D7;
      tick();
      checkCount++;
      if (state !== 3'd2 || p1Clear !== 1'b0 || p1En !== 1'b1)
         $display("[TB] FAIL p1_entry got st=%0d clr=%b en=%b exp st=2 clr=0 en=1", state, p1Clear, p1En);
      else passCount++;
      start = 1'b1;
      p2Done = 1'b1;
      tick();
      start = 1'b0;
      p2Done = 1'b0;
      checkCount++;
      if (state !== 3'd2) $display("[TB] FAIL p1_ignores_start_p2done got=%0d exp=2", state);
      else passCount++;
      p1Done = 1'b1;
      tick();
      p1Done = 1'b0;
      checkCount++;
      if (state !== 3'd3 || p1En !== 1'b0 || p2En !== 1'b1)
         $display("[TB] FAIL p2_entry got st=%0d en=%b%b exp st=3 en=01", state, p1En, p2En);
      else passCount++;
      p2Done = 1'b1;
      tick();
      p2Done = 1'b0;
      checkCount++;
      if (state !== 3'd4 || p2En !== 1'b0) $display("[TB] FAIL compare got st=%0d p2en=%b exp st=4 p2en=0", state, p2En);
      else passCount++;
      tick();
      checkCount++;
      if (state !== 3'd5 || roundMatch !== 1'b1 || score !== 4'd1 || roundNum !== 4'd1)
         $display("[TB] FAIL match_result got st=%0d m=%b sc=%0d rn=%0d exp st=5 m=1 sc=1 rn=1",
                  state, roundMatch, score, roundNum);
      else passCount++;
      tick();
      checkCount++;
      if (state !== 3'd1 || p1Clear !== 1'b1)
         $display("[TB] FAIL back_to_clear got st=%0d clr=%b exp st=1 clr=1", state, p1Clear);
      else passCount++;
   endtask

   task automatic test_mismatch();
      applyStimulus(10'h1D7, 10'h1D5);
      checkCount++;
      if (roundMatch !== 1'b0 || score !== 4'd1 || roundNum !== 4'd2)
         $display("[TB] FAIL mismatch got m=%b sc=%0d rn=%0d exp m=0 sc=1 rn=2", roundMatch, score, roundNum);
      else passCount++;
   endtask

   task automatic test_game_end();
      tick();
      checkCount++;
      if (state !== 3'd6 || gameOver !== 1'b1 || score !== 4'd1 || roundNum !== 4'd2)
         $display("[TB] FAIL game_over got st=%0d go=%b sc=%0d rn=%0d exp st=6 go=1 sc=1 rn=2",
                  state, gameOver, score, roundNum);
      else passCount++;
      p1Done = 1'b1;
      tick(2);
      p1Done = 1'b0;
      checkCount++;
      if (state !== 3'd6 || score !== 4'd1) $display("[TB] FAIL game_over_hold got st=%0d sc=%0d exp st=6 sc=1", state, score);
      else passCount++;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkCount++;
      if (state !== 3'd1 || score !== 4'd0 || roundNum !== 4'd0 || gameOver !== 1'b0 || roundMatch !== 1'b0)
         $display("[TB] FAIL restart got st=%0d sc=%0d rn=%0d go=%b m=%b exp st=1 sc=0 rn=0 go=0 m=0",
                  state, score, roundNum, gameOver, roundMatch);
      else passCount++;
   endtask

   task automatic test_empty_code();
      applyStimulus(10'h000, 10'h000);
      checkCount++;
      if (roundMatch !== 1'b0 || score !== 4'd0 || roundNum !== 4'd1)
         $display("[TB] FAIL empty_code got m=%b sc=%0d rn=%0d exp m=0 sc=0 rn=1", roundMatch, score, roundNum);
      else passCount++;
      tick();
      applyStimulus(10'h2AA, 10'h2AA);
      checkCount++;
      if (roundMatch !== 1'b1 || score !== 4'd1 || roundNum !== 4'd2)
         $display("[TB] FAIL second_game_match got m=%b sc=%0d rn=%0d exp m=1 sc=1 rn=2", roundMatch, score, roundNum);
      else passCount++;
      tick();
      checkCount++;
      if (state !== 3'd6) $display("[TB] FAIL second_game_over got=%0d exp=6", state);
      else passCount++;
   endtask

   task automatic test_timeout();
      start = 1'b1;
      tick();
      start = 1'b0;
      p1Code = 10'h1D7;
      p2Code = 10'h1D7;
      tick();
`ifdef ENTRY_TIMEOUT_EN
      tick(9);
      checkCount++;
      if (state !== 3'd2) $display("[TB] FAIL before_expiry got=%0d exp=2", state);
      else passCount++;
      tick();
      checkCount++;
      if (state !== 3'd4 || timeout !== 1'b1) $display("[TB] FAIL expiry got st=%0d to=%b exp st=4 to=1", state, timeout);
      else passCount++;
      tick();
      checkCount++;
      if (state !== 3'd5 || roundMatch !== 1'b0 || roundNum !== 4'd1 || score !== 4'd0 || timeout !== 1'b1)
         $display("[TB] FAIL timeout_result got st=%0d m=%b rn=%0d sc=%0d to=%b exp st=5 m=0 rn=1 sc=0 to=1",
                  state, roundMatch, roundNum, score, timeout);
      else passCount++;
      tick();
      checkCount++;
      if (state !== 3'd1 || timeout !== 1'b0) $display("[TB] FAIL timeout_cleared got st=%0d to=%b exp st=1 to=0", state, timeout);
      else passCount++;
      tick();
      tick(9);
      p1Done = 1'b1;
      tick();
      p1Done = 1'b0;
      checkCount++;
      if (state !== 3'd3 || timeout !== 1'b0) $display("[TB] FAIL done_beats_expiry got st=%0d to=%b exp st=3 to=0", state, timeout);
      else passCount++;
      p2Done = 1'b1;
      tick();
      p2Done = 1'b0;
      tick();
      checkCount++;
      if (roundMatch !== 1'b1 || score !== 4'd1 || roundNum !== 4'd2 || timeout !== 1'b0)
         $display("[TB] FAIL late_done_result got m=%b sc=%0d rn=%0d to=%b exp m=1 sc=1 rn=2 to=0",
                  roundMatch, score, roundNum, timeout);
      else passCount++;
      tick();
`else
      tick(12);
      checkCount++;
      if (state !== 3'd2 || timeout !== 1'b0) $display("[TB] FAIL no_timeout_wait got st=%0d to=%b exp st=2 to=0", state, timeout);
      else passCount++;
      tick(-1 + 1);
      p1Done = 1'b1;
      tick();
      p1Done = 1'b0;
      p2Done = 1'b1;
      tick();
      p2Done = 1'b0;
      tick();
      checkCount++;
      if (roundMatch !== 1'b1 || score !== 4'd1 || roundNum !== 4'd1 || timeout !== 1'b0)
         $display("[TB] FAIL slow_round_result got m=%b sc=%0d rn=%0d to=%b exp m=1 sc=1 rn=1 to=0",
                  roundMatch, score, roundNum, timeout);
      else passCount++;
      tick();
      applyStimulus(10'h155, 10'h155);
      tick();
`endif
      checkCount++;
      if (state !== 3'd6) $display("[TB] FAIL timeout_game_over got=%0d exp=6", state);
      else passCount++;
   endtask

   task automatic test_reset_mid_round();
      start = 1'b1;
      tick();
      start = 1'b0;
      applyStimulus(10'h0F3, 10'h0F3);
      tick(2);
      p1Done = 1'b1;
      tick();
      p1Done = 1'b0;
      checkCount++;
      if (state !== 3'd3 || score !== 4'd1 || p2En !== 1'b1)
         $display("[TB] FAIL pre_abort got st=%0d sc=%0d p2en=%b exp st=3 sc=1 p2en=1", state, score, p2En);
      else passCount++;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checkCount++;
      if (state !== 3'd0 || score !== 4'd0 || p2En !== 1'b0 || roundNum !== 4'd0)
         $display("[TB] FAIL abort got st=%0d sc=%0d p2en=%b rn=%0d exp st=0 sc=0 p2en=0 rn=0",
                  state, score, p2En, roundNum);
      else passCount++;
   endtask

   // Scenario sequence; each scenario picks up where the previous one left the DUT
   initial begin
      test_reset();
      test_match();
      test_mismatch();
      test_game_end();
      test_empty_code();
      test_timeout();
      test_reset_mid_round();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   // Hard stop in case a scenario stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
